// File: rtl/riscv_multi_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU control codes and datapath mux selects.
package riscv_multi_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU decoder: maps alu_op and the instruction function fields to
// an ALU control code, flagging funct3 values this core does not implement.
module riscv_alu_decoder
    import riscv_multi_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       bad_funct
);

    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5 = 1) uses funct7b5 to select sub.
                    3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: bad_funct   = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multi_controller.sv
// Main control FSM for the multicycle RV32I core. Define CTRL_INSTRET_EN to
// build the retired-instruction counter; otherwise instret reads as zero.
module riscv_multi_controller
    import riscv_multi_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic        reg_write,
    output logic [2:0]  alu_control,
    output logic        illegal,
    output logic [3:0]  state_o,
    output logic [31:0] instret
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_pcupdate, w_branch, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
    logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op;
    logic       w_op_bad, w_bad_funct, w_retire;

    always_comb begin
        w_pcupdate   = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_WD;
        w_alu_op     = ALUOP_ADD;
        w_op_bad     = 1'b0;
        w_next       = r_state;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pcupdate   = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_op_bad = 1'b1;
                        w_next   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = SRCA_A;
                w_alu_src_b = SRCB_IMM;
                w_next      = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                w_next    = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECR: begin
                w_alu_src_a = SRCA_A;
                w_alu_op    = ALUOP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a = SRCA_A;
                w_alu_src_b = SRCB_IMM;
                w_alu_op    = ALUOP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a = SRCA_A;
                w_alu_op    = ALUOP_SUB;
                w_branch    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_FOUR;
                w_pcupdate  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    riscv_alu_decoder u_alu_dec (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control),
        .bad_funct   (w_bad_funct)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | w_op_bad | w_bad_funct;
        end
    end

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                      (r_state == S_ALUWB) || (r_state == S_BEQ);

`ifdef CTRL_INSTRET_EN
    logic [31:0] r_instret;
    always_ff @(posedge clk) begin
        if (rst)
            r_instret <= 32'h0;
        else if (w_retire)
            r_instret <= r_instret + 32'd1;
    end
    assign instret = r_instret;
`else
    logic w_retire_unused;
    assign w_retire_unused = w_retire;
    assign instret         = 32'h0;
`endif

    // Architectural write enables are gated so nothing commits while in reset.
    assign pc_write    = ~rst & (w_pcupdate | (w_branch & zero));
    assign mem_write   = ~rst & w_mem_write;
    assign ir_write    = ~rst & w_ir_write;
    assign reg_write   = ~rst & w_reg_write;
    assign adr_src     = w_adr_src;
    assign result_src  = w_result_src;
    assign alu_src_a   = w_alu_src_a;
    assign alu_src_b   = w_alu_src_b;
    assign imm_src     = imm_sel(op);
    assign illegal     = r_illegal;
    assign state_o     = r_state;

endmodule
